// File: rtl/hes_ctr_stream_pkg.sv
// hes_pkg: shared definitions for the hes_ctr_stream counter-mode cipher engine.
//   HES_DATA_W_DEF / HES_ROUNDS_DEF : default data width and round count
//   HES_W_MAX                       : widest DATA_W the round function handles
//   hes_stage_t                     : pipeline payload {valid, data, ctr, s, k} at default width
//   hes_round(s, k, r[, w])         : one keystream round, rotl1(s) ^ (k + r), mod 2^w
package hes_pkg;

  localparam int HES_DATA_W_DEF = 8;
  localparam int HES_ROUNDS_DEF = 4;
  localparam int HES_W_MAX      = 64;

  typedef struct packed {
    logic                      valid;
    logic [HES_DATA_W_DEF-1:0] data;
    logic [HES_DATA_W_DEF-1:0] ctr;
    logic [HES_DATA_W_DEF-1:0] s;
    logic [HES_DATA_W_DEF-1:0] k;
  } hes_stage_t;

  // Operands are carried at HES_W_MAX bits; w selects the live width so one
  // function serves every DATA_W. The rotate wraps bit w-1 into bit 0.
  function automatic logic [HES_W_MAX-1:0] hes_round(
    input logic [HES_W_MAX-1:0] s,
    input logic [HES_W_MAX-1:0] k,
    input int unsigned          r,
    input int unsigned          w = HES_DATA_W_DEF
  );
    logic [HES_W_MAX-1:0] m;
    logic [HES_W_MAX-1:0] sm;
    logic [HES_W_MAX-1:0] rot;
    m   = (w >= HES_W_MAX) ? '1 : ((64'd1 << w) - 64'd1);
    sm  = s & m;
    rot = ((sm << 1) | (sm >> (w - 1))) & m;
    return rot ^ ((k + HES_W_MAX'(r)) & m);
  endfunction

endpackage

// File: rtl/hes_ctr_stream_if.sv
// hes_ctr_stream_if: input and output stream of the cipher engine.
//   key, iv, new_message, in_valid, in_data, in_ready : input beat handshake
//   out_valid, out_ready, out_data, out_ctr           : output beat handshake
//   modport master : source/sink side; modport slave : engine side
interface hes_ctr_stream_if #(
  parameter int DATA_W = hes_pkg::HES_DATA_W_DEF
);

  logic [DATA_W-1:0] key;
  logic [DATA_W-1:0] iv;
  logic              new_message;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_ctr;

  modport master (
    output key, iv, new_message, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ctr
  );

  modport slave (
    input  key, iv, new_message, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ctr
  );

endinterface

// File: rtl/hes_ctr_stream_ks_stage.sv
// hes_ks_stage: one registered keystream round of the hes_ctr_stream pipeline.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : pipeline advance; stage holds when low
//   d          : payload from the previous stage (s = s(R))
//   q          : registered payload (s = s(R+1)); valid, data, ctr, k pass through
module hes_ks_stage
  import hes_pkg::*;
#(
  parameter int          DATA_W  = HES_DATA_W_DEF,
  parameter int unsigned R       = 0,
  parameter type         stage_t = hes_stage_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  logic [DATA_W-1:0] s_next;

  assign s_next = DATA_W'(hes_round(HES_W_MAX'(d.s), HES_W_MAX'(d.k), R, DATA_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q.valid <= d.valid;
      q.data  <= d.data;
      q.ctr   <= d.ctr;
      q.k     <= d.k;
      q.s     <= s_next;
    end
  end

endmodule

// File: rtl/hes_ctr_stream.sv
// hes_ctr_stream: counter-mode stream cipher engine. Each accepted word is
// XORed with a keystream derived from the message key and a running counter
// through a ROUNDS-deep pipeline with valid/ready backpressure on both sides.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : hes_ctr_stream_if.slave (input beat, key/iv, output beat)
//   busy       : some pipeline stage holds a valid beat
//   wrap_err   : counter exhausted in the current message
// Optional feature: define HES_WRAP_ERR_EN to lock the input after a beat uses
// the all-ones counter until the next new_message beat; otherwise the counter
// wraps silently and wrap_err is tied 0.
module hes_ctr_stream
  import hes_pkg::*;
#(
  parameter int DATA_W = HES_DATA_W_DEF,
  parameter int ROUNDS = HES_ROUNDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hes_ctr_stream_if.slave       bus,
  output logic                  busy,
  output logic                  wrap_err
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] ctr;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] k;
  } stage_t;

  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] ctr_q;
  logic [DATA_W-1:0] use_key;
  logic [DATA_W-1:0] use_ctr;
  logic              wrap_lock;
  logic              adv;
  logic              accept;
  stage_t            st_in;
  stage_t            st_q [ROUNDS];
  stage_t            last;

  assign last   = st_q[ROUNDS-1];
  assign adv    = !last.valid || bus.out_ready;
  assign bus.in_ready = adv && (!wrap_lock || bus.new_message);
  assign accept = bus.in_valid && bus.in_ready;

  assign use_key = bus.new_message ? bus.key : key_q;
  assign use_ctr = bus.new_message ? bus.iv  : ctr_q;

  // A refused or absent beat enters as a bubble; bubbles are not compressed.
  always_comb begin
    st_in       = '0;
    st_in.valid = accept;
    st_in.data  = bus.in_data;
    st_in.ctr   = use_ctr;
    st_in.s     = use_ctr ^ use_key;
    st_in.k     = use_key;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
      ctr_q <= '0;
    end else if (accept) begin
      key_q <= use_key;
      ctr_q <= use_ctr + 1'b1;
    end
  end

  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    if (r == 0) begin : g_first
      hes_ks_stage #(.DATA_W(DATA_W), .R(r), .stage_t(stage_t)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .d     (st_in),
        .q     (st_q[r])
      );
    end else begin : g_rest
      hes_ks_stage #(.DATA_W(DATA_W), .R(r), .stage_t(stage_t)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .d     (st_q[r-1]),
        .q     (st_q[r])
      );
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < ROUNDS; r++) begin
      busy = busy | st_q[r].valid;
    end
  end

  assign bus.out_valid = last.valid;
  assign bus.out_data  = last.data ^ last.s;
  assign bus.out_ctr   = last.ctr;

`ifdef HES_WRAP_ERR_EN
  // Accept is only possible unlocked or on new_message, so the lock simply
  // follows whether the accepted beat used the last counter value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_lock <= 1'b0;
    end else if (accept) begin
      wrap_lock <= (use_ctr == '1);
    end
  end
  assign wrap_err = wrap_lock;
`else
  assign wrap_lock = 1'b0;
  assign wrap_err  = 1'b0;
`endif

endmodule

// File: tb/tb_hes_ctr_stream.sv
module tb_hes_ctr_stream;

  localparam int DW = 8;
  localparam int RN = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic wrap_err;

  always #5 clk = ~clk;

  hes_ctr_stream_if #(.DATA_W(DW)) bus ();

  hes_ctr_stream #(.DATA_W(DW), .ROUNDS(RN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .wrap_err (wrap_err)
  );

  typedef struct {
    logic [7:0] key;
    logic [7:0] iv;
    logic       nm;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic [7:0] exp_ctr;
  } vec_t;

  typedef struct {
    logic [7:0] key;
    logic [7:0] iv;
    logic       nm;
    logic [7:0] data;
  } beat_t;

  vec_t       vt [6];
  beat_t      bq [$];
  logic [7:0] mon_d [$];
  logic [7:0] mon_c [$];
  logic [7:0] exp_d [$];
  logic [7:0] exp_c [$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      mon_d.push_back(bus.out_data);
      mon_c.push_back(bus.out_ctr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_beat(input beat_t b);
    bus.key         = b.key;
    bus.iv          = b.iv;
    bus.new_message = b.nm;
    bus.in_data     = b.data;
  endtask

  function automatic beat_t mk(input logic [7:0] k, input logic [7:0] v,
                               input logic n, input logic [7:0] d);
    beat_t b;
    b.key = k; b.iv = v; b.nm = n; b.data = d;
    return b;
  endfunction

  task automatic expect_out(input logic [7:0] d, input logic [7:0] c);
    exp_d.push_back(d);
    exp_c.push_back(c);
  endtask

  task automatic clear_q();
    mon_d.delete(); mon_c.delete(); exp_d.delete(); exp_c.delete(); bq.delete();
  endtask

  // Offers bq beats back to back from the next cycle on; out_ready is low for
  // stall_len cycles starting at cycle stall_at of this sequence.
  task automatic drive_stream(input string name, input int stall_at, input int stall_len);
    int   idx = 0;
    int   cyc = 0;
    logic acc;
    @(posedge clk); #1;
    while (idx < bq.size() && cyc < 100) begin
      set_beat(bq[idx]);
      bus.in_valid  = 1'b1;
      bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      acc = bus.in_ready;
      if (bus.out_valid && !bus.out_ready)
        check({name, "_ready_stalled"}, {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid    = 1'b0;
    bus.new_message = 1'b0;
    bus.out_ready   = 1'b1;
    check({name, "_all_accepted"}, idx, bq.size());
  endtask

  task automatic wait_and_compare(input string name);
    int t = 0;
    while (mon_d.size() < exp_d.size() && t < 60) begin
      @(negedge clk);
      t++;
    end
    repeat (RN + 2) @(negedge clk);
    check({name, "_count"}, mon_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < mon_d.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), {24'd0, mon_d[i]}, {24'd0, exp_d[i]});
      check($sformatf("%s_ctr%0d", name, i), {24'd0, mon_c[i]}, {24'd0, exp_c[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // key0 keystream reduces to rotl4(ctr) ^ 03; the others are worked by hand.
    vt[0] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h03, 8'h00};
    vt[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h13, 8'h01};
    vt[2] = '{8'h01, 8'h10, 1'b1, 8'hFF, 8'hEC, 8'h10};
    vt[3] = '{8'h00, 8'hFE, 1'b1, 8'h00, 8'hEC, 8'hFE};
    vt[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'hFC, 8'hFF};
    vt[5] = '{8'hAA, 8'h55, 1'b1, 8'h0F, 8'hFF, 8'h55};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.new_message = 1'b0;
    bus.key         = '0;
    bus.iv          = '0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, bus.out_data},  32'd0);
    check("rst_out_ctr",   {24'd0, bus.out_ctr},   32'd0);
    check("rst_busy",      {31'd0, busy},          32'd0);
    check("rst_wrap_err",  {31'd0, wrap_err},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // Single-beat vectors: latency, keystream and counter sequencing.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_beat(mk(vt[i].key, vt[i].iv, vt[i].nm, vt[i].data));
      bus.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.out_valid && lat < 20);
      check($sformatf("vec%0d_latency", i), lat, RN);
      check($sformatf("vec%0d_out_data", i), {24'd0, bus.out_data}, {24'd0, vt[i].exp_data});
      check($sformatf("vec%0d_out_ctr", i),  {24'd0, bus.out_ctr},  {24'd0, vt[i].exp_ctr});
    end

    // Backpressure: 6 beats, out_ready low for 3 cycles while output is valid.
    repeat (RN + 2) @(negedge clk);
    clear_q();
    for (int i = 0; i < 6; i++) begin
      bq.push_back(mk(8'h00, 8'h00, (i == 0), 8'(i)));
      expect_out(8'(((i << 4) | 3) ^ i), 8'(i));
    end
    drive_stream("bp", 4, 3);
    wait_and_compare("bp");

    // Message switch with earlier beats still in flight.
    clear_q();
    bq.push_back(mk(8'h00, 8'h00, 1'b1, 8'h00));
    bq.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00));
    bq.push_back(mk(8'h01, 8'h10, 1'b1, 8'h55));
    expect_out(8'h03, 8'h00);
    expect_out(8'h13, 8'h01);
    expect_out(8'h46, 8'h10);
    drive_stream("switch", 1000, 0);
    wait_and_compare("switch");

    // Counter wrap from FE.
    clear_q();
    expect_out(8'hEC, 8'hFE);
    expect_out(8'hFC, 8'hFF);
    expect_out(8'h03, 8'h00);
`ifdef HES_WRAP_ERR_EN
    bq.push_back(mk(8'h00, 8'hFE, 1'b1, 8'h00));
    bq.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00));
    drive_stream("wrap", 1000, 0);
    @(negedge clk);
    check("wrap_err_set", {31'd0, wrap_err}, 32'd1);
    @(posedge clk); #1;
    set_beat(mk(8'h00, 8'h00, 1'b0, 8'h00));
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("wrap_refused", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    set_beat(mk(8'h00, 8'h00, 1'b1, 8'h00));
    @(negedge clk);
    check("wrap_nm_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.new_message = 1'b0;
    @(negedge clk);
    check("wrap_err_cleared", {31'd0, wrap_err}, 32'd0);
`else
    bq.push_back(mk(8'h00, 8'hFE, 1'b1, 8'h00));
    bq.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00));
    bq.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00));
    drive_stream("wrap", 1000, 0);
    @(negedge clk);
    check("wrap_err_tied", {31'd0, wrap_err}, 32'd0);
`endif
    wait_and_compare("wrap");

    // Reset with three beats in flight.
    clear_q();
    bq.push_back(mk(8'h01, 8'h10, 1'b1, 8'h00));
    bq.push_back(mk(8'h01, 8'h10, 1'b0, 8'h00));
    bq.push_back(mk(8'h01, 8'h10, 1'b0, 8'h00));
    drive_stream("rstmid", 1000, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rstmid_out_data",  {24'd0, bus.out_data},  32'd0);
    check("rstmid_out_ctr",   {24'd0, bus.out_ctr},   32'd0);
    check("rstmid_busy",      {31'd0, busy},          32'd0);
    check("rstmid_in_ready",  {31'd0, bus.in_ready},  32'd1);
    repeat (8) @(negedge clk);
    check("rstmid_no_output", mon_d.size(), 0);
    clear_q();
    bq.push_back(mk(8'h77, 8'h77, 1'b0, 8'h00));
    expect_out(8'h03, 8'h00);
    drive_stream("postrst", 1000, 0);
    wait_and_compare("postrst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
